atm_dos_ctrl: RTL
=================

# atm_dos_ctrl

Holds the DOS (TR-DOS ROM) state flag and generates the Z80 clock stall that follows a DOS turn-on. It sits directly downstream of the four per-window ATM pagers. It ORs their single-cycle `dos_turn_on` / `dos_turn_off` strobes into one registered `dos` flag. That flag feeds back to every pager's `dos` input and to the ROM-page select.

## Interface
Parameters:
- `STALL_CYCLES`, default 4: number of `fclk` cycles `zclk_stall` is held after a DOS turn-on. Range 0..15; 0 means no stall.

Ports:
- `fclk`  in  1  system clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `zpos`  in  1  Z80 clock rising-edge strobe. Used only to time the CP/M re-sync.
- `dos_turn_on`  in  4  per-window turn-on strobes from the pagers (bit n = window n); each is a 1-cycle pulse.
- `dos_turn_off`  in  4  per-window turn-off strobes from the pagers; each is a 1-cycle pulse.
- `pager_off`  in  1  ATM2 PEN; while 1, all turn-on/turn-off strobes are ignored.
- `cpm_n`  in  1  ATM CP/M mode, active low; while 0, `dos` is forced to 1.
- `dos`  out  1  registered DOS state.
- `zclk_stall`  out  1  registered; freezes the Z80 clock generator while 1.
- `dos_chg`  out  1  1-cycle pulse on every change of `dos`.

## Operation
- `on = |dos_turn_on & ~pager_off` and `off = |dos_turn_off & ~pager_off`.
- `dos` next-state, in priority order:
  - `cpm_n==0` → 1.
  - `on` → 1. `on` beats `off` when both fire in the same cycle.
  - `off` → 0.
  - Otherwise hold.
- `dos_chg` is 1 in the cycle after `dos` takes a new value. It is computed as the registered next-state compared with the current `dos`.
- Stall FSM, states IDLE / STALL, with a 4-bit counter `cnt`:
  - IDLE → STALL when `dos` rises 0→1 and `STALL_CYCLES!=0`.
    - Applies whether the rise is caused by `on` or by `cpm_n` falling.
    - On entry, `cnt` is loaded with `STALL_CYCLES-1`.
  - In STALL, `cnt` decrements each `fclk`. STALL → IDLE when `cnt==0`.
  - `zclk_stall` = (state==STALL).
  - `on` while `dos` is already 1 does not retrigger the stall.
  - `off` during STALL clears `dos` but does not shorten the stall.
  - A 0→1→0→1 sequence inside one stall does not extend or restart it.
- CP/M re-sync: when `cpm_n` rises (0→1), `dos` keeps its value.
  - It is released to normal strobe control at the first `zpos` after the rise.
  - Strobes arriving before that `zpos` are ignored.

## Timing
- Reset values: `dos`=0, `zclk_stall`=0, `dos_chg`=0, state=IDLE, `cnt`=0. CP/M re-sync is cleared at reset.
- Strobe to `dos` latency: 1 `fclk`. A strobe sampled at edge k shows on `dos` after edge k.
- `zclk_stall` rises on the same edge as `dos` rises. It stays high for exactly `STALL_CYCLES` `fclk` cycles.
- `rst` asserted mid-stall drops `zclk_stall` and `dos` asynchronously. After release, the block starts in IDLE.
- Strobes are trusted to be single-cycle; the block does not edge-detect them.

## Configuration
- `ATM_DOS_STALL_EN`:
  - Defined: stall FSM and counter are built as described above.
  - Undefined: no FSM or counter is built, `zclk_stall` is tied to 0, and `STALL_CYCLES` is ignored.
  - `dos` and `dos_chg` behave identically in both builds.

## Test plan
- **Reset and turn-on stall:** reset; pulse `dos_turn_on`=4'b0001 for 1 cycle → `dos`=1 next cycle, `dos_chg` pulses once, `zclk_stall`=1 for exactly 4 cycles (STALL_CYCLES=4).
- **Simultaneous strobes:** with `dos`=0, `dos_turn_on`=4'b0001 and `dos_turn_off`=4'b0100 in the same cycle → `dos`=1, stall starts.
- **Turn-off during stall:** with `dos`=1 and stall active, `dos_turn_off`=4'b1000 → `dos`=0 next cycle, `zclk_stall` still ends at cycle 4; a second `dos_turn_on` mid-stall does not extend it.
- **Pager off:** `pager_off`=1 plus `dos_turn_on`=4'b1111 → `dos` and `zclk_stall` stay 0.
- **CP/M force and release:** `cpm_n`=0 → `dos`=1 and a 4-cycle stall. Then `cpm_n`=1 and `dos_turn_off` before the first `zpos` → `dos` stays 1. `dos_turn_off` after that `zpos` → `dos`=0.
- **Reset mid-stall and no-stall build:** assert `rst` at stall cycle 2 → `zclk_stall`=0 and `dos`=0 immediately. Separately, build without `ATM_DOS_STALL_EN` and repeat the first scenario → `zclk_stall` never 1.

Source files
------------

// File: rtl/atm_dos_ctrl_if.sv
// Pager-side bundle for atm_dos_ctrl: merged DOS strobes, CP/M and PEN
// controls going in, DOS flag / Z80 clock stall / change pulse coming out.
interface atm_dos_ctrl_if;
  logic       zpos;
  logic [3:0] dos_turn_on;
  logic [3:0] dos_turn_off;
  logic       pager_off;
  logic       cpm_n;
  logic       dos;
  logic       zclk_stall;
  logic       dos_chg;

  // Pager / environment side: drives strobes, sees the DOS state.
  modport master (
    output zpos, dos_turn_on, dos_turn_off, pager_off, cpm_n,
    input  dos, zclk_stall, dos_chg
  );

  // Controller side.
  modport slave (
    input  zpos, dos_turn_on, dos_turn_off, pager_off, cpm_n,
    output dos, zclk_stall, dos_chg
  );
endinterface

// File: rtl/atm_dos_ctrl.sv
// atm_dos_ctrl: merges the per-window pager DOS strobes into one registered
// DOS flag, forces DOS during ATM CP/M mode, and stalls the Z80 clock for
// STALL_CYCLES fclk cycles after every DOS turn-on.
//
// Optional feature macro: ATM_DOS_STALL_EN
//   defined   -> stall FSM and down-counter are built
//   undefined -> zclk_stall is tied low, STALL_CYCLES has no effect
//
// Stall FSM states:
//   state    | meaning
//   ST_IDLE  | Z80 clock free-running; waiting for a DOS 0->1 rise
//   ST_STALL | Z80 clock frozen; cnt counts down to terminal count 0
module atm_dos_ctrl #(
  parameter int unsigned STALL_CYCLES = 4
) (
  input  logic          fclk,
  input  logic          rst,
  atm_dos_ctrl_if.slave bus
);

  // A zero stall length disables the stall even when the FSM is built.
  localparam bit          STALL_EN   = (STALL_CYCLES != 0);
  localparam int unsigned LOAD_INT   = STALL_EN ? (STALL_CYCLES - 1) : 0;
  localparam logic [3:0]  STALL_LOAD = 4'(LOAD_INT);

  logic on_req;
  logic off_req;
  logic cpm_n_d;
  logic cpm_rise;
  logic resync;
  logic strobe_gate;
  logic dos_q;
  logic dos_nxt;
  logic dos_chg_q;
  logic dos_rise;

  // PEN masks every strobe; any window may turn DOS on or off.
  assign on_req  = (|bus.dos_turn_on)  & ~bus.pager_off;
  assign off_req = (|bus.dos_turn_off) & ~bus.pager_off;

  // Leaving CP/M keeps DOS frozen until the Z80 clock phase is known again,
  // i.e. until the first zpos after cpm_n rises; strobes in between are lost.
  assign cpm_rise    = bus.cpm_n & ~cpm_n_d;
  assign strobe_gate = ~resync & ~cpm_rise;

  // Track cpm_n edges and the CP/M re-sync window.
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      cpm_n_d <= 1'b1;
      resync  <= 1'b0;
    end else begin
      cpm_n_d <= bus.cpm_n;
      if (!bus.cpm_n)
        resync <= 1'b0;
      else if (cpm_rise)
        resync <= 1'b1;
      else if (bus.zpos)
        resync <= 1'b0;
    end
  end

  // DOS next state: CP/M force, then turn-on, then turn-off, else hold.
  always_comb begin
    dos_nxt = dos_q;
    if (!bus.cpm_n)
      dos_nxt = 1'b1;
    else if (strobe_gate && on_req)
      dos_nxt = 1'b1;
    else if (strobe_gate && off_req)
      dos_nxt = 1'b0;
  end

  // Register the DOS flag and a one-cycle change pulse aligned with it.
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      dos_q     <= 1'b0;
      dos_chg_q <= 1'b0;
    end else begin
      dos_q     <= dos_nxt;
      dos_chg_q <= (dos_nxt != dos_q);
    end
  end

  assign dos_rise    = dos_nxt & ~dos_q;
  assign bus.dos     = dos_q;
  assign bus.dos_chg = dos_chg_q;

`ifdef ATM_DOS_STALL_EN
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  logic [0:0] state;
  logic [3:0] cnt;

  // Stall timer: load on DOS rise, count down, leave at terminal count.
  // Rises seen while already stalling neither restart nor extend it.
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (dos_rise && STALL_EN) begin
            state <= ST_STALL;
            cnt   <= STALL_LOAD;
          end
        end
        ST_STALL: begin
          if (cnt == 4'd0)
            state <= ST_IDLE;
          else
            cnt <= cnt - 4'd1;
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign bus.zclk_stall = (state == ST_STALL);
`else
  // No stall hardware: the Z80 clock is never frozen by this block.
  assign bus.zclk_stall = STALL_EN & 1'b0;
`endif

endmodule
